// File: rtl/mul_iter_unit_pkg.sv
// Shared definitions for the iterative shift-add multiplier: operation
// encodings, FSM state encoding and the default operand width.
package mul_iter_unit_pkg;

    localparam int MUL_WIDTH = 32;

    localparam logic [1:0] MUL_OP_MUL   = 2'b00;
    localparam logic [1:0] MUL_OP_MLA   = 2'b01;
    localparam logic [1:0] MUL_OP_UMULL = 2'b10;
    localparam logic [1:0] MUL_OP_SMULL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // Long multiplies (UMULL/SMULL) produce both halves of the product.
    function automatic logic is_long_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mul_iter_datapath.sv
// Datapath of the iterative multiplier: operand registers, the 2W-bit
// accumulate adder, multiplicand shifter, sign fix-up and result/flag registers.
module mul_iter_datapath
    import mul_iter_unit_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic               step,
    input  logic               last,
    input  logic [1:0]         op_in,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic [WIDTH-1:0]   src_acc,
    output logic [WIDTH-1:0]   result_lo,
    output logic [WIDTH-1:0]   result_hi,
    output logic               flag_n,
    output logic               flag_z
);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               neg;
    logic [1:0]         op;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic               a_neg;
    logic               b_neg;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;
    logic               n_next;
    logic               z_next;

    // Operand conditioning: SMULL works on magnitudes; the most negative value
    // negates to itself, which read as unsigned is its true magnitude.
    always_comb begin
        a_neg = (op_in == MUL_OP_SMULL) && src_a[WIDTH-1];
        b_neg = (op_in == MUL_OP_SMULL) && src_b[WIDTH-1];
        a_abs = a_neg ? (~src_a + 1'b1) : src_a;
        b_abs = b_neg ? (~src_b + 1'b1) : src_b;
    end

    // One add per step, then sign fix-up of the running sum for the final write.
    always_comb begin
        acc_next = mplier[0] ? (acc + mcand) : acc;
        prod     = neg ? (~acc_next + 1'b1) : acc_next;
        if (is_long_op(op)) begin
            n_next = prod[2*WIDTH-1];
            z_next = (prod == '0);
        end else begin
            n_next = prod[WIDTH-1];
            z_next = (prod[WIDTH-1:0] == '0);
        end
    end

    // Operand and accumulator registers; multiplicand shifts left instead of a
    // variable shift by count, which keeps the adder input a plain register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            op     <= MUL_OP_MUL;
        end else if (clear) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            op     <= MUL_OP_MUL;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a_abs};
            mplier <= b_abs;
            acc    <= (op_in == MUL_OP_MLA) ? {{WIDTH{1'b0}}, src_acc} : '0;
            neg    <= a_neg ^ b_neg;
            op     <= op_in;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // Result and flag registers; written only on the last step, held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_lo <= '0;
            result_hi <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
        end else if (clear) begin
            result_lo <= '0;
            result_hi <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
        end else if (step && last) begin
            result_lo <= prod[WIDTH-1:0];
            result_hi <= is_long_op(op) ? prod[2*WIDTH-1:WIDTH] : '0;
            flag_n    <= n_next;
            flag_z    <= z_next;
        end
    end

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative radix-2 multiplier for MUL/MLA/UMULL/SMULL. Holds the control FSM
// and step counter; arithmetic lives in mul_iter_datapath.
// Handshake: start is sampled only in IDLE; busy rises on the accepting edge
// and stays high through the single-cycle done pulse; results are valid from
// the done cycle and hold until the next completion, reset or clear.
module mul_iter_unit
    import mul_iter_unit_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       MulOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [WIDTH-1:0] SrcAcc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic             N,
    output logic             Z,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_e     state;
    mul_state_e     state_nxt;
    logic [CW-1:0]  count;
    logic           load;
    logic           step;
    logic           last;

    // State register; clear aborts to IDLE on the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Step counter: zeroed on accept, advanced once per BUSY cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || load) begin
            count <= '0;
        end else if (step) begin
            count <= count + 1'b1;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = (count == CW'(WIDTH - 1));
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

    mul_iter_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .load      (load),
        .step      (step),
        .last      (last),
        .op_in     (MulOp),
        .src_a     (SrcA),
        .src_b     (SrcB),
        .src_acc   (SrcAcc),
        .result_lo (ResultLo),
        .result_hi (ResultHi),
        .flag_n    (N),
        .flag_z    (Z)
    );

endmodule
